// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared constants for the 16/8 restoring divider datapath.
//   DVD_W / DVS_W : dividend / divisor widths
//   R_W           : partial-remainder width (one guard bit over the divisor)
//   STEP_*        : sequencer state codes that the datapath decodes
// Optional feature macro (used by div_datapath): DIV_SIGNED_EN
// ---------------------------------------------------------------------------
package div_pkg;

   localparam int DVD_W = 16;
   localparam int DVS_W = 8;
   localparam int R_W   = DVS_W + 1;

   localparam logic [3:0] STEP_IDLE       = 4'd0;
   localparam logic [3:0] STEP_LOAD       = 4'd1;
   localparam logic [3:0] STEP_ITER_FIRST = 4'd2;
   localparam logic [3:0] STEP_ITER_LAST  = 4'd9;
   localparam logic [3:0] STEP_FIX        = 4'd10;
   localparam logic [3:0] STEP_WB         = 4'd11;

   // True for the eight restoring iterations.
   function automatic logic is_iter(input logic [3:0] step);
      return (step >= STEP_ITER_FIRST) && (step <= STEP_ITER_LAST);
   endfunction

   // True while an operation is between LOAD and WB inclusive.
   function automatic logic is_busy(input logic [3:0] step);
      return (step >= STEP_LOAD) && (step <= STEP_WB);
   endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration: shift {r,q} left by one,
// trial-subtract the divisor from the shifted remainder, keep the difference
// and shift in a 1 when it is non-negative, else keep the shifted remainder
// and shift in a 0.
// Ports:
//   r     in  [R_W-1:0]   partial remainder
//   q     in  [DVS_W-1:0] quotient / low-dividend shift register
//   dvs   in  [DVS_W-1:0] divisor (magnitude)
//   r_nxt out [R_W-1:0]   next partial remainder
//   q_nxt out [DVS_W-1:0] next shift register
// ---------------------------------------------------------------------------
module div_step
   import div_pkg::*;
(
   input  logic [R_W-1:0]   r,
   input  logic [DVS_W-1:0] q,
   input  logic [DVS_W-1:0] dvs,
   output logic [R_W-1:0]   r_nxt,
   output logic [DVS_W-1:0] q_nxt
);

   logic [R_W-1:0] r_sh;
   logic [R_W:0]   trial;
   logic           ge;

   // The shift pushes r[8] out of the 9-bit window; if it was set the true
   // shifted value is >= 256 and therefore >= any divisor, and the 9-bit
   // difference is still exact because the result is below 2*divisor.
   assign r_sh  = {r[R_W-2:0], q[DVS_W-1]};
   assign trial = {1'b0, r_sh} - {2'b00, dvs};
   assign ge    = r[R_W-1] | ~trial[R_W];

   assign r_nxt = ge ? trial[R_W-1:0] : r_sh;
   assign q_nxt = {q[DVS_W-2:0], ge};

endmodule

// File: rtl/div_datapath.sv
// ---------------------------------------------------------------------------
// div_datapath
// 16/8 restoring divider datapath (AX / divisor -> AL quotient, AH remainder)
// stepped by an external sequencer through state codes on STEP.
// Ports:
//   CLK  in   clock, registers update on the rising edge
//   RST  in   asynchronous active-high reset
//   STEP in  [3:0]  sequencer state (1 LOAD, 2..9 iterate, 10 FIX, 11 WB)
//   DVD  in  [15:0] dividend, sampled at LOAD only
//   DVS  in  [7:0]  divisor, sampled at LOAD only
//   SGN  in         signed divide (only with DIV_SIGNED_EN)
//   QUO  out [7:0]  quotient
//   REM  out [7:0]  remainder
//   DONE out        one-cycle strobe after WB
//   DERR out        divide error, held until the next LOAD
//   BUSY out        STEP in 1..11 (combinational)
// Optional feature macro: DIV_SIGNED_EN (IDIV: adds SGN and the sign fix-up)
// ---------------------------------------------------------------------------
module div_datapath
   import div_pkg::*;
(
   input  logic             CLK,
   input  logic             RST,
   input  logic [3:0]       STEP,
   input  logic [DVD_W-1:0] DVD,
   input  logic [DVS_W-1:0] DVS,
`ifdef DIV_SIGNED_EN
   input  logic             SGN,
`endif
   output logic [DVS_W-1:0] QUO,
   output logic [DVS_W-1:0] REM,
   output logic             DONE,
   output logic             DERR,
   output logic             BUSY
);

   logic [R_W-1:0]   r_q, r_nxt;
   logic [DVS_W-1:0] q_q, q_nxt;
   logic [DVS_W-1:0] dvs_q;
   logic [DVD_W-1:0] dvd_mag;
   logic [DVS_W-1:0] dvs_mag;

`ifdef DIV_SIGNED_EN
   logic sgn_q, neg_dvd_q, neg_dvs_q;

   // Signed operands enter the unsigned core as magnitudes; 0x8000 and 0x80
   // map onto themselves, which is the correct unsigned magnitude.
   always_comb begin
      dvd_mag = DVD;
      dvs_mag = DVS;
      if (SGN && DVD[DVD_W-1]) dvd_mag = -DVD;
      if (SGN && DVS[DVS_W-1]) dvs_mag = -DVS;
   end
`else
   assign dvd_mag = DVD;
   assign dvs_mag = DVS;
`endif

   assign BUSY = is_busy(STEP);

   div_step u_step (
      .r     (r_q),
      .q     (q_q),
      .dvs   (dvs_q),
      .r_nxt (r_nxt),
      .q_nxt (q_nxt)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_q   <= '0;
         q_q   <= '0;
         dvs_q <= '0;
         QUO   <= '0;
         REM   <= '0;
         DONE  <= 1'b0;
         DERR  <= 1'b0;
`ifdef DIV_SIGNED_EN
         sgn_q     <= 1'b0;
         neg_dvd_q <= 1'b0;
         neg_dvs_q <= 1'b0;
`endif
      end else begin
         // Only the cycle after a WB edge strobes; abandoning earlier never does.
         DONE <= (STEP == STEP_WB);

         if (STEP == STEP_LOAD) begin
            r_q   <= {1'b0, dvd_mag[DVD_W-1:DVS_W]};
            q_q   <= dvd_mag[DVS_W-1:0];
            dvs_q <= dvs_mag;
            // High byte >= divisor means the quotient cannot fit 8 bits
            // (also catches a zero divisor).
            DERR  <= (dvd_mag[DVD_W-1:DVS_W] >= dvs_mag);
`ifdef DIV_SIGNED_EN
            sgn_q     <= SGN;
            neg_dvd_q <= SGN & DVD[DVD_W-1];
            neg_dvs_q <= SGN & DVS[DVS_W-1];
`endif
         end else if (is_iter(STEP)) begin
            if (!DERR) begin
               r_q <= r_nxt;
               q_q <= q_nxt;
            end
`ifdef DIV_SIGNED_EN
         end else if (STEP == STEP_FIX) begin
            if (!DERR && sgn_q) begin
               // Magnitude above 127 cannot be represented as a signed byte.
               if (q_q[DVS_W-1]) DERR <= 1'b1;
               if (neg_dvd_q ^ neg_dvs_q) q_q <= -q_q;
               if (neg_dvd_q)             r_q <= -r_q;
            end
`endif
         end else if (STEP == STEP_WB) begin
            if (!DERR) begin
               QUO <= q_q;
               REM <= r_q[DVS_W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_div_datapath.sv
// ---------------------------------------------------------------------------
// tb_div_datapath
// Table-driven plus random stimulus for div_datapath; expected results are
// queued when an operation is launched and popped when DONE is observed.
// Build with +define+DIV_SIGNED_EN to include the signed cases.
// ---------------------------------------------------------------------------
module tb_div_datapath;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  STEP;
   logic [15:0] DVD;
   logic [7:0]  DVS;
`ifdef DIV_SIGNED_EN
   logic        SGN;
`endif
   logic [7:0]  QUO, REM;
   logic        DONE, DERR, BUSY;

   div_datapath dut (
      .CLK  (CLK),
      .RST  (RST),
      .STEP (STEP),
      .DVD  (DVD),
      .DVS  (DVS),
`ifdef DIV_SIGNED_EN
      .SGN  (SGN),
`endif
      .QUO  (QUO),
      .REM  (REM),
      .DONE (DONE),
      .DERR (DERR),
      .BUSY (BUSY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       e;
   } exp_t;

   typedef struct {
      logic [15:0] dvd;
      logic [7:0]  dvs;
      logic [7:0]  q;
      logic [7:0]  r;
      logic        e;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[10];

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] mq = 8'h00, mr = 8'h00;   // last committed quotient/remainder

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step_to(input logic [3:0] s);
      @(negedge CLK);
      STEP = s;
   endtask

   // One full LOAD..WB operation; operands are scrambled after LOAD so the
   // result must come from the sampled values only.
   task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs, input logic sgn,
                         input logic [7:0] eq, input logic [7:0] er, input logic ee);
      exp_t x, got;
      x.q = eq; x.r = er; x.e = ee;
      sb.push_back(x);
      @(negedge CLK);
      STEP = 4'd1; DVD = dvd; DVS = dvs;
`ifdef DIV_SIGNED_EN
      SGN = sgn;
`endif
      step_to(4'd2);
      DVD = 16'($urandom); DVS = 8'($urandom);
      if (!sgn) chk("derr_after_load", {15'd0, DERR}, {15'd0, ee});
      for (int s = 3; s <= 11; s++) begin
         step_to(4'(s));
         if (s == 6) chk("busy_mid", {15'd0, BUSY}, 16'd1);
      end
      @(negedge CLK);
      chk("done_pulse", {15'd0, DONE}, 16'd1);
      if (sb.size() == 0) begin
         n_tests++; n_fail++;
         $display("FAIL scoreboard_empty: got DONE expected no pending op");
      end else begin
         got = sb.pop_front();
         chk("quo", {8'd0, QUO}, {8'd0, got.q});
         chk("rem", {8'd0, REM}, {8'd0, got.r});
         chk("derr", {15'd0, DERR}, {15'd0, got.e});
      end
      STEP = 4'd0;
      @(negedge CLK);
      chk("done_clear", {15'd0, DONE}, 16'd0);
      chk("busy_idle", {15'd0, BUSY}, 16'd0);
      if (!ee) begin mq = eq; mr = er; end
   endtask

   initial begin
      logic [7:0]  rd_dvs, eq, er;
      logic [15:0] rd_dvd;
      logic        ee;

      tbl[0] = '{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0};
      tbl[1] = '{16'h1234, 8'h00, 8'h0E, 8'h02, 1'b1};
      tbl[2] = '{16'h0700, 8'h07, 8'h0E, 8'h02, 1'b1};
      tbl[3] = '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0};
      tbl[4] = '{16'hFFFF, 8'h01, 8'hFF, 8'hFE, 1'b1};
      tbl[5] = '{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0};
      tbl[6] = '{16'h0000, 8'h05, 8'h00, 8'h00, 1'b0};
      tbl[7] = '{16'h03E8, 8'h0A, 8'h64, 8'h00, 1'b0};
      tbl[8] = '{16'h1234, 8'h13, 8'hF5, 8'h05, 1'b0};
      tbl[9] = '{16'h0100, 8'h02, 8'h80, 8'h00, 1'b0};

      RST = 1'b1; STEP = 4'd0; DVD = 16'h0; DVS = 8'h0;
`ifdef DIV_SIGNED_EN
      SGN = 1'b0;
`endif
      #1;
      chk("rst_quo",  {8'd0, QUO}, 16'h0);
      chk("rst_rem",  {8'd0, REM}, 16'h0);
      chk("rst_done", {15'd0, DONE}, 16'h0);
      chk("rst_derr", {15'd0, DERR}, 16'h0);
      chk("rst_busy", {15'd0, BUSY}, 16'h0);
      @(negedge CLK);
      RST = 1'b0;

      for (int i = 0; i < 10; i++)
         run_op(tbl[i].dvd, tbl[i].dvs, 1'b0, tbl[i].q, tbl[i].r, tbl[i].e);

      // Random operands, occasionally overflowing; reference uses / and %.
      for (int i = 0; i < 16; i++) begin
         rd_dvs = 8'($urandom_range(0, 255));
         rd_dvd = 16'($urandom);
         if (i % 4 != 0 && rd_dvs != 8'd0)
            rd_dvd[15:8] = 8'($urandom_range(0, int'(rd_dvs) - 1));
         ee = (rd_dvd[15:8] >= rd_dvs);
         eq = ee ? mq : 8'(rd_dvd / {8'd0, rd_dvs});
         er = ee ? mr : 8'(rd_dvd % {8'd0, rd_dvs});
         run_op(rd_dvd, rd_dvs, 1'b0, eq, er, ee);
      end

      // Abandon: return to idle mid-iteration; no DONE, results untouched.
      step_to(4'd1); DVD = 16'h0050; DVS = 8'h03;
      step_to(4'd2); step_to(4'd3); step_to(4'd4); step_to(4'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("abandon_no_done", {15'd0, DONE}, 16'd0);
      end
      chk("abandon_quo", {8'd0, QUO}, {8'd0, mq});
      chk("abandon_rem", {8'd0, REM}, {8'd0, mr});

      // Asynchronous reset at STEP=5, then recovery.
      run_op(16'h0064, 8'h07, 1'b0, 8'h0E, 8'h02, 1'b0);
      step_to(4'd1); DVD = 16'hFEFF; DVS = 8'hFF;
      for (int s = 2; s <= 5; s++) step_to(4'(s));
      #2 RST = 1'b1;
      #1;
      chk("midrst_quo",  {8'd0, QUO}, 16'h0);
      chk("midrst_rem",  {8'd0, REM}, 16'h0);
      chk("midrst_derr", {15'd0, DERR}, 16'h0);
      chk("midrst_done", {15'd0, DONE}, 16'h0);
      @(negedge CLK);
      RST = 1'b0; STEP = 4'd0;
      @(negedge CLK);
      chk("midrst_no_done", {15'd0, DONE}, 16'd0);
      mq = 8'h00; mr = 8'h00;
      run_op(16'h0064, 8'h07, 1'b0, 8'h0E, 8'h02, 1'b0);

`ifdef DIV_SIGNED_EN
      run_op(16'hFF9C, 8'h07, 1'b1, 8'hF2, 8'hFE, 1'b0);   // -100 / 7
      run_op(16'h0080, 8'h01, 1'b1, 8'hF2, 8'hFE, 1'b1);   // 128 overflows
      run_op(16'h0064, 8'hF9, 1'b1, 8'hF2, 8'h02, 1'b0);   // 100 / -7
      run_op(16'hFF9C, 8'hF9, 1'b1, 8'h0E, 8'hFE, 1'b0);   // -100 / -7
      run_op(16'hFEFF, 8'hFF, 1'b0, 8'hFF, 8'hFE, 1'b0);   // SGN=0 stays unsigned
`endif

      if (sb.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/div_datapath.md
DIV_DATAPATH -- requirements
Module: div_datapath

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all registers update on the rising edge, while the divider sequencer changes STEP on the falling edge.
REQ-002 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port STEP, input, 4, current state code T0..T15 from the divider sequencer.
REQ-004 SHALL have port DVD, input, 16, dividend (AX).
REQ-005 SHALL have port DVS, input, 8, divisor.
REQ-006 SHALL have port SGN, input, 1, 1 = signed divide; present only with DIV_SIGNED_EN.
REQ-007 SHALL have port QUO, output, 8, quotient (AL).
REQ-008 SHALL have port REM, output, 8, remainder (AH).
REQ-009 SHALL have port DONE, output, 1, one-cycle result strobe.
REQ-010 SHALL have port DERR, output, 1, divide error; held until the next load.
REQ-011 SHALL have port BUSY, output, 1, operation in progress.

Function
REQ-012 SHALL sample DVD and DVS only on the rising edge while STEP=1 (LOAD); inputs are ignored at all other steps.
REQ-013 SHALL, at LOAD, set the 9-bit partial remainder R={0,DVD[15:8]} and the shift register Q=DVD[7:0], clear DERR, and set DERR if DVD[15:8] >= DVS (this includes DVS=0).
REQ-014 SHALL, at each of STEP=2..9 (8 iterations), shift {R,Q} left by one, compute trial=R-{0,DVS} (9-bit), and then:
- if trial >= 0: set R=trial and Q[0]=1;
- otherwise: leave R unchanged and set Q[0]=0.
REQ-015 SHALL hold R and Q during STEP=2..10 when DERR=1.
REQ-016 SHALL treat STEP=10 (FIX) as a no-op unless DIV_SIGNED_EN is defined.
REQ-017 SHALL, at STEP=11 (WB) with DERR=0, load QUO=Q[7:0] and REM=R[7:0]; when DERR=1, QUO and REM SHALL keep their previous values.
REQ-018 SHALL assert DONE for exactly the one cycle following the WB rising edge, regardless of DERR.
REQ-019 SHALL hold QUO, REM and DERR stable from WB until the next LOAD.
REQ-020 SHALL drive BUSY=1 combinationally when STEP is in 1..11, and 0 otherwise.
REQ-021 SHALL treat STEP=0 and STEP=12..15 as idle with no register change.
REQ-022 SHALL, if STEP returns to 0 before WB, abandon the operation: no DONE, and QUO/REM unchanged.

Reset
REQ-023 SHALL, while RST=1, asynchronously force QUO=0x00, REM=0x00, DONE=0, DERR=0, R=0 and Q=0, including mid-operation.
REQ-024 SHALL resume normal operation at the next LOAD after RST deasserts.

Configuration
REQ-025 SHALL support the macro DIV_SIGNED_EN for the IDIV feature:
- without it: unsigned DIV only, and no SGN port;
- with it: SGN present, and the signed behaviour in REQ-026..REQ-028 applies.
REQ-026 SHALL, with DIV_SIGNED_EN and SGN=1 at LOAD, convert DVD and DVS to magnitudes, record the dividend and divisor signs, and apply the REQ-013 overflow check to the magnitudes.
REQ-027 SHALL, with DIV_SIGNED_EN and SGN=1 at FIX:
- set DERR if Q[7]=1 (quotient magnitude > 127);
- negate Q if the signs differed;
- negate R if the dividend was negative.
REQ-028 SHALL, with DIV_SIGNED_EN and SGN=0, behave exactly as the unsigned path.

Structure
REQ-029 SHALL take the step-code constants (STEP_LOAD=1, STEP_ITER_FIRST=2, STEP_ITER_LAST=9, STEP_FIX=10, STEP_WB=11) and the width constants (DVD_W=16, DVS_W=8) from the shared package div_pkg.
REQ-030 SHALL implement one restoring iteration (shift, trial subtract, select) as the combinational sub-module div_step, instantiated once.

Verification
REQ-031 SHALL cover: DVD=0x0064, DVS=0x07 -> QUO=0x0E, REM=0x02, DERR=0, DONE pulse after STEP=11.
REQ-032 SHALL cover: DVD=0x1234, DVS=0x00 -> DERR=1 after LOAD, DONE pulses, QUO/REM keep previous values.
REQ-033 SHALL cover: DVD=0x0700, DVS=0x07 -> DERR=1 (quotient overflow); then DVD=0xFEFF, DVS=0xFF -> QUO=0xFF, REM=0xFE, DERR=0.
REQ-034 SHALL cover: RST pulsed while STEP=5 -> QUO=REM=0x00, DERR=0, no DONE; the next operation computes correctly.
REQ-035 SHALL cover: DVD changed during STEP=2..11 -> result reflects the value sampled at LOAD only.
REQ-036 SHALL cover, with DIV_SIGNED_EN: SGN=1, DVD=0xFF9C (-100), DVS=0x07 -> QUO=0xF2 (-14), REM=0xFE (-2); and DVD=0x0080, DVS=0x01 -> DERR=1.
